// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller.
//   - state_e    : frame FSM state encoding (binary, 3 bits)
//   - PAR_*      : parity type select values
//   - line level : idle, start and stop bit levels of the TX line
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator.
//   data_i     : byte being sent
//   par_typ_i  : PAR_EVEN / PAR_ODD
//   par_bit_o  : bit that makes the total count of ones even (or odd)
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic         par_typ_i,
  output logic         par_bit_o
);

  // XOR reduce gives even parity; odd parity is its inverse.
  assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller.
// Sequences start bit, 8 serialized data bits, optional parity bit and
// stop bit onto TX_OUT at one bit per CLK.
//   CLK, RST          : bit clock, synchronous active-high reset
//   P_DATA, Data_Valid: byte and one-cycle request from upstream
//   PAR_EN, PAR_TYP   : parity enable / type, latched on accept
//   ser_done, ser_data: serializer last-bit flag and current bit
//   ser_en, busy      : serializer shift enable, frame in progress
//   TX_OUT, TX_DONE   : serial line, last-cycle-of-stop pulse
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [P_DATA_WIDTH-1:0] P_DATA,
  input  logic                    Data_Valid,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  input  logic                    ser_done,
  input  logic                    ser_data,
  output logic                    ser_en,
  output logic                    busy,
  output logic                    TX_OUT,
  output logic                    TX_DONE
);

  state_e state_q, state_d;
  logic   par_bit_q, par_bit_d;
  logic   par_en_q,  par_en_d;
  logic   par_bit_calc;
  logic   accept;

  uart_parity_calc #(.W(P_DATA_WIDTH)) u_par (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (par_bit_calc)
  );

  assign accept = (state_q == IDLE) && Data_Valid;

  // PAR_TYP only matters through the parity bit, so it is folded into
  // par_bit_q at accept; mid-frame changes of PAR_EN/PAR_TYP are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          par_bit_d = par_bit_calc;
          par_en_d  = PAR_EN;
        end
      end
      START:   state_d = DATA;
      DATA: begin
        if (ser_done) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, except ser_data in DATA.
  always_comb begin
    TX_OUT = LINE_IDLE;
    case (state_q)
      START:   TX_OUT = START_BIT;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit_q;
      STOP:    TX_OUT = STOP_BIT;
      default: TX_OUT = LINE_IDLE;
    endcase
  end

  assign ser_en  = (state_q == DATA);
  assign busy    = (state_q != IDLE);
  assign TX_DONE = (state_q == STOP);

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done, ser_data;
  logic       ser_en, busy, TX_OUT, TX_DONE;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.P_DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT),
    .TX_DONE    (TX_DONE)
  );

  // Behavioural serializer: loads on Data_Valid while not busy, shifts
  // LSB first while ser_en, flags the 8th bit.
  logic [7:0] sh;
  int         cnt;
  always @(posedge CLK) begin
    if (RST) begin
      sh <= 8'h00; cnt <= 0;
    end else if (Data_Valid && !busy) begin
      sh <= P_DATA; cnt <= 0;
    end else if (ser_en) begin
      sh <= sh >> 1; cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = ser_en && (cnt == 7);

  // Expected {TX_OUT, busy, ser_en, TX_DONE} for cycle k (1 = start bit)
  // of a frame, derived from the frame format.
  function automatic logic [3:0] exp_cycle(input logic [7:0] d, input logic pe,
                                           input logic pt, input int k);
    int  n;
    logic par, tx;
    n   = pe ? 11 : 10;
    par = logic'($countones(d) % 2) ^ pt;
    if (k == 1)               tx = 1'b0;
    else if (k <= 9)          tx = d[k-2];
    else if (pe && k == 10)   tx = par;
    else                      tx = 1'b1;
    return {tx, 1'b1, (k >= 2 && k <= 9), (k == n)};
  endfunction

  // One idle cycle check, accept, then the whole frame cycle by cycle.
  // noise: extra Data_Valid pulses and control/data changes mid-frame.
  task automatic tx_frame(input string nm, input logic [7:0] d, input logic pe,
                          input logic pt, input bit noise);
    int n;
    logic [3:0] obs, exp;
    n = pe ? 11 : 10;
    @(negedge CLK);
    n_chk++;
    obs = {TX_OUT, busy, ser_en, TX_DONE};
    if (obs !== 4'b1000)
      $display("FAIL %s idle-before: got %b want 1000", nm, obs);
    else n_pass++;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      obs = {TX_OUT, busy, ser_en, TX_DONE};
      exp = exp_cycle(d, pe, pt, k);
      n_chk++;
      if (obs !== exp)
        $display("FAIL %s cycle%0d {tx,busy,en,done}: got %b want %b", nm, k, obs, exp);
      else n_pass++;
      if (noise && k < n) begin
        if (k == 3 || k == 10) Data_Valid = 1'b1;
        if (k == 4) P_DATA = 8'($urandom);
        if (k == 5) PAR_TYP = ~PAR_TYP;
        if (k == 6) PAR_EN = ~PAR_EN;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      obs = {TX_OUT, busy, ser_en, TX_DONE};
      n_chk++;
      if (obs !== 4'b1000) $display("FAIL reset idle%0d: got %b want 1000", i, obs);
      else n_pass++;
    end
  endtask

  task automatic test_parity_frames();
    tx_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
    tx_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0);
    tx_frame("00_nopar", 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Noisy frame followed by an accept in the very first IDLE cycle.
    tx_frame("noise_a5", 8'hA5, 1'b1, 1'b0, 1'b1);
    tx_frame("b2b_5a",   8'h5A, 1'b1, 1'b1, 1'b0);
    tx_frame("noise_np", 8'hC3, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    logic [3:0] obs;
    @(negedge CLK);
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);   // START
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);   // now in 4th data-bit cycle
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    obs = {TX_OUT, busy, ser_en, TX_DONE};
    n_chk++;
    if (obs !== 4'b1000) $display("FAIL rst_mid after-reset: got %b want 1000", obs);
    else n_pass++;
    tx_frame("after_rst_3c", 8'h3C, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_rst_with_valid();
    logic [3:0] obs;
    @(negedge CLK);
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h81;
    @(negedge CLK);
    RST = 1'b0; Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = {TX_OUT, busy, ser_en, TX_DONE};
      n_chk++;
      if (obs !== 4'b1000) $display("FAIL rst_dv idle%0d: got %b want 1000", i, obs);
      else n_pass++;
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      tx_frame($sformatf("rand%0d", i), 8'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_parity_frames();
    test_back_to_back();
    test_reset_midframe();
    test_rst_with_valid();
    test_random();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
